// File: rtl/hw9_sdiv_pkg.sv
// Shared types and constants for the hw9 signed-divider sequencing controller.
// State encoding, default sizing and strobe-vector bit positions live here.
package hw9_sdiv_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SHIFT = 3'd2,
      S_SUB   = 3'd3,
      S_CMP   = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_LOAD  = S_LOAD;
   localparam logic [2:0] ST_SHIFT = S_SHIFT;
   localparam logic [2:0] ST_SUB   = S_SUB;
   localparam logic [2:0] ST_CMP   = S_CMP;
   localparam logic [2:0] ST_DONE  = S_DONE;

   localparam int N_BITS_DEF = 4;
   localparam int CNT_W_DEF  = 4;

   localparam int STB_LOAD  = 0;
   localparam int STB_SHIFT = 1;
   localparam int STB_SUB   = 2;
   localparam int STB_CMP   = 3;
   localparam int STB_W     = 4;

endpackage

// File: rtl/hw9_sdiv_ctrl_if.sv
// Requester/datapath-facing signal bundle of the divider sequencing controller.
// Handshake: start is a level request sampled only while idle (no back-pressure,
// no queuing); busy covers LOAD..last COMPARE; done is a one-cycle result-valid pulse.
interface hw9_sdiv_ctrl_if;
   import hw9_sdiv_pkg::*;

   logic   start;
   logic   abort;
   logic   div_zero;
   logic   Load;
   logic   Shift;
   logic   Sub;
   logic   Compare;
   logic   busy;
   logic   done;
   logic   err;
   state_e dbg_state;

   modport master (
      output start, abort, div_zero,
      input  Load, Shift, Sub, Compare, busy, done, err, dbg_state
   );

   modport slave (
      input  start, abort, div_zero,
      output Load, Shift, Sub, Compare, busy, done, err, dbg_state
   );

endinterface

// File: rtl/hw9_sdiv_itcnt.sv
// Iteration counter for the divider controller: clear, increment and a flag
// marking the final iteration (count == N_BITS-1).
module hw9_sdiv_itcnt #(
   parameter int N_BITS = 4,
   parameter int CNT_W  = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic last_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign last_o = (cnt_q == CNT_W'(N_BITS - 1));

   // Saturate at the last iteration so the count never leaves 0..N_BITS-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !last_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hw9_sdiv_ctrl.sv
// Moore sequencer driving Load/Shift/Sub/Compare through N_BITS restoring iterations.
// Optional divide-by-zero short-cut enabled by defining HW9_SDIV_DIVZERO_EN.
module hw9_sdiv_ctrl
   import hw9_sdiv_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset_n,
   hw9_sdiv_ctrl_if.slave ctrl
);

   logic [2:0]       state_q, state_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_last;
   logic [STB_W-1:0] stb;

`ifdef HW9_SDIV_DIVZERO_EN
   logic err_q, err_d;
`endif

   hw9_sdiv_itcnt #(
      .N_BITS (N_BITS),
      .CNT_W  (CNT_W)
   ) u_itcnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_inc),
      .last_o  (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
`ifdef HW9_SDIV_DIVZERO_EN
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ctrl.start) begin
`ifdef HW9_SDIV_DIVZERO_EN
               if (ctrl.div_zero) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_LOAD;
                  err_d   = 1'b0;
               end
`else
               state_d = ST_LOAD;
`endif
            end
         end
         ST_LOAD: begin
            cnt_clr = 1'b1;
            state_d = ctrl.abort ? ST_IDLE : ST_SHIFT;
         end
         ST_SHIFT: state_d = ctrl.abort ? ST_IDLE : ST_SUB;
         ST_SUB:   state_d = ctrl.abort ? ST_IDLE : ST_CMP;
         ST_CMP: begin
            // Abort outranks the end-of-division check: no done pulse after a cancel.
            if (ctrl.abort) begin
               state_d = ST_IDLE;
            end else if (cnt_last) begin
               state_d = ST_DONE;
            end else begin
               cnt_inc = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs decode the state register only, so reset clears them without a clock.
   always_comb begin
      stb = '0;
      case (state_q)
         ST_LOAD:  stb[STB_LOAD]  = 1'b1;
         ST_SHIFT: stb[STB_SHIFT] = 1'b1;
         ST_SUB:   stb[STB_SUB]   = 1'b1;
         ST_CMP:   stb[STB_CMP]   = 1'b1;
         default:  stb = '0;
      endcase
   end

   assign ctrl.Load      = stb[STB_LOAD];
   assign ctrl.Shift     = stb[STB_SHIFT];
   assign ctrl.Sub       = stb[STB_SUB];
   assign ctrl.Compare   = stb[STB_CMP];
   assign ctrl.busy      = |stb;
   assign ctrl.done      = (state_q == ST_DONE);
   assign ctrl.dbg_state = state_e'(state_q);

`ifdef HW9_SDIV_DIVZERO_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign ctrl.err = err_q;
`else
   logic unused_div_zero;
   assign unused_div_zero = ctrl.div_zero;
   assign ctrl.err        = 1'b0;
`endif

endmodule

// File: tb/tb_hw9_sdiv_ctrl.sv
// Bench for hw9_sdiv_ctrl: timeline reference model feeds an expected queue,
// a negedge monitor compares outputs and datapath results against it.
module tb_hw9_sdiv_ctrl;
   import hw9_sdiv_pkg::*;

   localparam int N        = 4;
   localparam int LAST_ACT = 3 * N + 1;
   localparam int DONE_OFF = 3 * N + 2;
`ifdef HW9_SDIV_DIVZERO_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   hw9_sdiv_ctrl_if bus ();

   hw9_sdiv_ctrl #(
      .N_BITS (N),
      .CNT_W  (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ctrl    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output vector: {Load, Shift, Sub, Compare, busy, done, err}
   logic [6:0] exp_q[$];
   // Datapath expectation: {check, quotient[3:0], remainder[3:0]}
   logic [8:0] dp_exp_q[$];

   // Model: position within the division timeline (0 = idle) and the err flag.
   int         m_off = 0;
   bit         m_err = 1'b0;
   logic [7:0] dp_w1 = 8'd0;
   logic [3:0] dp_w2 = 4'd0;

   // Behavioural restoring datapath driven by the controller strobes.
   logic [4:0] dp_rem;
   logic [3:0] dp_quo;
   logic [3:0] dp_div;
   logic [5:0] dp_trial;

   always @(posedge clk) begin
      if (bus.Load) begin
         dp_rem <= {1'b0, dp_w1[7:4]};
         dp_quo <= dp_w1[3:0];
         dp_div <= dp_w2;
      end else if (bus.Shift) begin
         dp_rem <= {dp_rem[3:0], dp_quo[3]};
         dp_quo <= {dp_quo[2:0], 1'b0};
      end else if (bus.Sub) begin
         dp_trial <= {1'b0, dp_rem} - {2'b00, dp_div};
      end else if (bus.Compare) begin
         if (!dp_trial[5]) begin
            dp_rem    <= dp_trial[4:0];
            dp_quo[0] <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d state=%0d got=%0h exp=%0h", name, cyc, bus.dbg_state, got, exp);
      end
   endtask

   function automatic logic [6:0] exp_vec(input int off, input bit e);
      logic [6:0] v;
      v = '0;
      if (off == 1) begin
         v[6] = 1'b1;
      end else if (off >= 2 && off <= LAST_ACT) begin
         case ((off - 2) % 3)
            0:       v[5] = 1'b1;
            1:       v[4] = 1'b1;
            default: v[3] = 1'b1;
         endcase
      end
      v[2] = (off >= 1 && off <= LAST_ACT);
      v[1] = (off == DONE_OFF);
      v[0] = e;
      return v;
   endfunction

   // Advance the model by one clock edge given this cycle's inputs.
   task automatic model_step(input bit st, input bit ab, input bit dz,
                             input logic [7:0] w1, input logic [3:0] w2);
      logic [3:0] q;
      logic [3:0] r;
      if (m_off == 0) begin
         if (st) begin
            dp_w1 = w1;
            dp_w2 = w2;
            if (DZ_EN && dz) begin
               m_off = DONE_OFF;
               m_err = 1'b1;
               dp_exp_q.push_back(9'd0);
            end else begin
               m_off = 1;
               m_err = 1'b0;
               q = (w2 != 0) ? 4'(w1 / w2) : 4'd0;
               r = (w2 != 0) ? 4'(w1 % w2) : 4'd0;
               dp_exp_q.push_back({(w2 != 4'd0), q, r});
            end
         end
      end else if (m_off <= LAST_ACT && ab) begin
         m_off = 0;
         void'(dp_exp_q.pop_back());
      end else if (m_off == DONE_OFF) begin
         m_off = 0;
      end else begin
         m_off++;
      end
      exp_q.push_back(exp_vec(m_off, m_err));
   endtask

   task automatic drive_cycle(input bit st, input bit ab, input logic [7:0] w1, input logic [3:0] w2);
      bus.start    = st;
      bus.abort    = ab;
      bus.div_zero = (w2 == 4'd0);
      model_step(st, ab, (w2 == 4'd0), w1, w2);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops(input bit allow_zero, output logic [7:0] w1, output logic [3:0] w2);
      if (allow_zero && $urandom_range(0, 7) == 0) begin
         w2 = 4'd0;
         w1 = 8'($urandom_range(0, 255));
      end else begin
         w2 = 4'($urandom_range(1, 15));
         w1 = 8'($urandom_range(0, int'(w2) * 16 - 1));
      end
   endtask

   task automatic seed_epoch();
      exp_q.push_back(exp_vec(m_off, m_err));
      mon_en = 1'b1;
   endtask

   always @(negedge clk) begin
      logic [6:0] ev;
      logic [8:0] de;
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            check("outputs", {bus.Load, bus.Shift, bus.Sub, bus.Compare, bus.busy, bus.done, bus.err}, ev);
         end else begin
            check("exp_queue_nonempty", 0, 1);
         end
         check("strobe_onehot", ($countones({bus.Load, bus.Shift, bus.Sub, bus.Compare}) <= 1), 1);
         if (bus.done) begin
            if (dp_exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               de = dp_exp_q.pop_front();
               if (de[8]) check("quotient_remainder", {dp_quo, dp_rem[3:0]}, de[7:0]);
            end
         end
      end
   end

   initial begin
      logic [7:0] w1;
      logic [3:0] w2;
      reset_n      = 1'b0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.div_zero = 1'b0;
      #2;
      check("reset_outputs", {bus.Load, bus.Shift, bus.Sub, bus.Compare, bus.busy, bus.done, bus.err}, 7'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      seed_epoch();

      // Directed pair: 13/3 then 27/5 restarted in the IDLE cycle after DONE.
      drive_cycle(1'b1, 1'b0, 8'd13, 4'd3);
      repeat (14) drive_cycle(1'b0, 1'b0, 8'd13, 4'd3);
      drive_cycle(1'b1, 1'b0, 8'd27, 4'd5);
      repeat (16) drive_cycle(1'b0, 1'b0, 8'd27, 4'd5);

      // start held high: one Load every 15 cycles.
      repeat (45) begin
         rand_ops(1'b0, w1, w2);
         drive_cycle(1'b1, 1'b0, w1, w2);
      end
      repeat (16) drive_cycle(1'b0, 1'b0, w1, w2);

      // Random start pulses, many while busy.
      repeat (60) begin
         rand_ops(1'b0, w1, w2);
         drive_cycle(($urandom_range(0, 2) == 0), 1'b0, w1, w2);
      end
      repeat (16) drive_cycle(1'b0, 1'b0, w1, w2);

      // Abort in the COMPARE of iteration 2, then an immediate restart.
      drive_cycle(1'b1, 1'b0, 8'd100, 4'd7);
      repeat (6) drive_cycle(1'b0, 1'b0, 8'd100, 4'd7);
      drive_cycle(1'b0, 1'b1, 8'd100, 4'd7);
      drive_cycle(1'b1, 1'b0, 8'd58, 4'd9);
      repeat (16) drive_cycle(1'b0, 1'b0, 8'd58, 4'd9);

      // Divide by zero, then a normal division.
      drive_cycle(1'b1, 1'b0, 8'd99, 4'd0);
      repeat (16) drive_cycle(1'b0, 1'b0, 8'd99, 4'd0);
      drive_cycle(1'b1, 1'b0, 8'd77, 4'd6);
      repeat (16) drive_cycle(1'b0, 1'b0, 8'd77, 4'd6);

      // Asynchronous reset while in SUB (cycle 6 after start).
      drive_cycle(1'b1, 1'b0, 8'd45, 4'd4);
      repeat (5) drive_cycle(1'b0, 1'b0, 8'd45, 4'd4);
      check("pre_reset_in_sub", bus.Sub, 1);
      mon_en = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      check("reset_mid_sub", {bus.Load, bus.Shift, bus.Sub, bus.Compare, bus.busy, bus.done, bus.err}, 7'd0);
      exp_q.delete();
      dp_exp_q.delete();
      m_off = 0;
      m_err = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      seed_epoch();
      repeat (10) drive_cycle(1'b0, 1'b0, 8'd45, 4'd4);

      // Random mix of starts, aborts and zero divisors.
      repeat (300) begin
         rand_ops(1'b1, w1, w2);
         drive_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), w1, w2);
      end
      repeat (20) drive_cycle(1'b0, 1'b0, w1, w2);

      check("dp_queue_drained", dp_exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
